// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// pong_pkg : state encoding, playfield/ball/paddle dimensions, coordinate type
// Revision : 1.0
// ============================================================================
package pong_pkg;

  localparam int SCREEN_W  = 240;
  localparam int SCREEN_H  = 320;
  localparam int BALL_SIZE = 8;
  localparam int PADDLE_W  = 48;
  localparam int PADDLE_H  = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MOVE   = 2'd1;
  localparam logic [1:0] ST_SCORED = 2'd2;

  // Signed working width wide enough for 2*limit - next without overflow.
  typedef logic signed [10:0] coord_t;

endpackage
`default_nettype wire

// File: rtl/ball_axis.sv
`default_nettype none
// ============================================================================
// ball_axis : combinational single-axis step with reflection about lo/hi limits
// Revision  : 1.0
// ============================================================================
module ball_axis
  import pong_pkg::*;
(
  input  logic [8:0] pos_i,
  input  logic       dir_i,
  input  logic [2:0] speed_i,
  input  coord_t     lo_i,
  input  coord_t     hi_i,
  output logic [8:0] pos_o,
  output logic       dir_o,
  output logic       oor_o
);

  coord_t w_cur;
  coord_t w_step;
  coord_t w_next;
  coord_t w_refl;

  always_comb begin
    w_cur  = $signed({2'b00, pos_i});
    w_step = $signed({8'd0, speed_i});
    w_next = dir_i ? (w_cur + w_step) : (w_cur - w_step);
    w_refl = w_next;
    dir_o  = dir_i;
    oor_o  = 1'b0;
    if (w_next < lo_i) begin
      w_refl = (lo_i <<< 1) - w_next;
      dir_o  = 1'b1;
      oor_o  = 1'b1;
    end else if (w_next > hi_i) begin
      w_refl = (hi_i <<< 1) - w_next;
      dir_o  = 1'b0;
      oor_o  = 1'b1;
    end
    pos_o = 9'(w_refl);
  end

endmodule
`default_nettype wire

// File: rtl/ball_physics.sv
`default_nettype none
// ============================================================================
// ball_physics : per-frame ball motion, wall/paddle reflection, serve/point/hold
// Revision     : 1.0
// ============================================================================
module ball_physics
  import pong_pkg::*;
#(
  parameter int SCREEN_W    = pong_pkg::SCREEN_W,
  parameter int SCREEN_H    = pong_pkg::SCREEN_H,
  parameter int BALL_SIZE   = pong_pkg::BALL_SIZE,
  parameter int PADDLE_W    = pong_pkg::PADDLE_W,
  parameter int PADDLE_H    = pong_pkg::PADDLE_H,
  parameter int SPEED       = 2,
  parameter int HOLD_FRAMES = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       refreshRate,
  input  logic       serve,
  input  logic [8:0] paddleTopX,
  input  logic [8:0] paddleBotX,
  output logic [8:0] ballX,
  output logic [8:0] ballY,
  output logic       dirX,
  output logic       dirY,
  output logic       active,
  output logic       pointTop,
  output logic       pointBot
);

  localparam logic [8:0] CX   = 9'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [8:0] CY   = 9'(SCREEN_H / 2 - BALL_SIZE / 2);
  localparam coord_t     XMIN = 11'sd0;
  localparam coord_t     XMAX = 11'(SCREEN_W - BALL_SIZE);
  localparam coord_t     YMIN = 11'(PADDLE_H);
  localparam coord_t     YMAX = 11'(SCREEN_H - PADDLE_H - BALL_SIZE);
  localparam int         HOLD_W    = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  logic [1:0]        state_q, state_d;
  logic [8:0]        ballX_q, ballX_d;
  logic [8:0]        ballY_q, ballY_d;
  logic              dirX_q, dirX_d;
  logic              dirY_q, dirY_d;
  logic              active_q, active_d;
  logic              pointTop_q, pointTop_d;
  logic              pointBot_q, pointBot_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [8:0]  w_nx, w_ny;
  logic        w_ndx, w_ndy;
  logic        w_xoor, w_yoor;
  logic [10:0] w_bx, w_padx;
  logic        w_overlap;

  ball_axis u_axis_x (
    .pos_i   (ballX_q),
    .dir_i   (dirX_q),
    .speed_i (3'(SPEED)),
    .lo_i    (XMIN),
    .hi_i    (XMAX),
    .pos_o   (w_nx),
    .dir_o   (w_ndx),
    .oor_o   (w_xoor)
  );

  ball_axis u_axis_y (
    .pos_i   (ballY_q),
    .dir_i   (dirY_q),
    .speed_i (3'(SPEED)),
    .lo_i    (YMIN),
    .hi_i    (YMAX),
    .pos_o   (w_ny),
    .dir_o   (w_ndy),
    .oor_o   (w_yoor)
  );

  // Paddle test uses the X position already updated on this tick.
  assign w_bx      = {2'b00, w_nx};
  assign w_padx    = {2'b00, (dirY_q ? paddleBotX : paddleTopX)};
  assign w_overlap = ((w_bx + 11'(BALL_SIZE)) > w_padx) &&
                     (w_bx < (w_padx + 11'(PADDLE_W)));

  always_comb begin
    state_d    = state_q;
    ballX_d    = ballX_q;
    ballY_d    = ballY_q;
    dirX_d     = dirX_q;
    dirY_d     = dirY_q;
    hold_d     = hold_q;
    pointTop_d = 1'b0;
    pointBot_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (serve) state_d = ST_MOVE;
      end
      ST_MOVE: begin
        if (refreshRate) begin
          ballX_d = w_nx;
          dirX_d  = w_ndx;
          if (w_yoor && !w_overlap) begin
            ballY_d    = dirY_q ? 9'(YMAX) : 9'(YMIN);
            pointTop_d = dirY_q;
            pointBot_d = !dirY_q;
            hold_d     = '0;
            state_d    = ST_SCORED;
          end else begin
            ballY_d = w_ny;
            dirY_d  = w_ndy;
          end
        end
      end
      ST_SCORED: begin
        if (refreshRate) begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HOLD_LAST) begin
            // dirY still points at the wall that was missed, i.e. toward the conceder.
            state_d = ST_IDLE;
            ballX_d = CX;
            ballY_d = CY;
            dirX_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    active_d = (state_d == ST_MOVE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ballX_q    <= CX;
      ballY_q    <= CY;
      dirX_q     <= 1'b1;
      dirY_q     <= 1'b1;
      active_q   <= 1'b0;
      pointTop_q <= 1'b0;
      pointBot_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      ballX_q    <= ballX_d;
      ballY_q    <= ballY_d;
      dirX_q     <= dirX_d;
      dirY_q     <= dirY_d;
      active_q   <= active_d;
      pointTop_q <= pointTop_d;
      pointBot_q <= pointBot_d;
      hold_q     <= hold_d;
    end
  end

  assign ballX    = ballX_q;
  assign ballY    = ballY_q;
  assign dirX     = dirX_q;
  assign dirY     = dirY_q;
  assign active   = active_q;
  assign pointTop = pointTop_q;
  assign pointBot = pointBot_q;

endmodule
`default_nettype wire

// File: tb/tb_ball_physics.sv
`default_nettype none
// ============================================================================
// tb_ball_physics : scoreboard bench for ball_physics with default parameters
// Revision        : 1.0
// ============================================================================
module tb_ball_physics;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       refreshRate = 1'b0;
  logic       serve = 1'b0;
  logic [8:0] paddleTopX = 9'd0;
  logic [8:0] paddleBotX = 9'd0;
  logic [8:0] ballX, ballY;
  logic       dirX, dirY, active, pointTop, pointBot;

  ball_physics dut (
    .clock       (clock),
    .reset       (reset),
    .refreshRate (refreshRate),
    .serve       (serve),
    .paddleTopX  (paddleTopX),
    .paddleBotX  (paddleBotX),
    .ballX       (ballX),
    .ballY       (ballY),
    .dirX        (dirX),
    .dirY        (dirY),
    .active      (active),
    .pointTop    (pointTop),
    .pointBot    (pointBot)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [22:0] v;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [22:0] obs;

  assign obs = {ballX, ballY, dirX, dirY, active, pointTop, pointBot};

  function automatic logic [22:0] ev(int x, int y, bit dx, bit dy, bit a, bit pt, bit pb);
    return {9'(x), 9'(y), dx, dy, a, pt, pb};
  endfunction

  function automatic exp_t mk(string n, logic [22:0] v);
    exp_t t;
    t.name = n;
    t.v    = v;
    return t;
  endfunction

  // One clock edge with the given inputs, then release them 1 ns after the edge.
  task automatic drive(bit t, bit s);
    refreshRate = t;
    serve       = s;
    @(posedge clock);
    #1;
    refreshRate = 1'b0;
    serve       = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1, 1);
    drive(1, 1);
    reset = 1'b0;
    exp_q.push_back(mk("reset_state", ev(116, 156, 1, 1, 0, 0, 0)));
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    end
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(mk($sformatf("idle_tick%0d", k), ev(116, 156, 1, 1, 0, 0, 0)));
      drive(1, 0);
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
      end
    end
  endtask

  task automatic test_serve_motion;
    exp_q.push_back(mk("serve_no_motion", ev(116, 156, 1, 1, 1, 0, 0)));
    drive(1, 1);
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back(mk($sformatf("move_tick%0d", k), ev(116 + 2 * k, 156 + 2 * k, 1, 1, 1, 0, 0)));
    end
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    end
    for (int k = 1; k <= 10; k++) begin
      drive(1, 0);
      e = exp_q.pop_front();
      n_vec++;
      if (obs !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
      end
    end
  endtask

  // Continues from tick 10 of the served ball.
  task automatic test_right_wall;
    for (int k = 11; k <= 59; k++) begin
      if (k == 58) exp_q.push_back(mk("wall_tick58", ev(232, 272, 1, 1, 1, 0, 0)));
      if (k == 59) exp_q.push_back(mk("wall_tick59", ev(230, 274, 0, 1, 1, 0, 0)));
      drive(1, 0);
      if (k >= 58) begin
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e.v) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
    end
  endtask

  task automatic test_bottom_hit;
    paddleBotX = 9'd180;
    for (int k = 60; k <= 75; k++) begin
      if (k == 74) exp_q.push_back(mk("bot_tick74", ev(200, 304, 0, 1, 1, 0, 0)));
      if (k == 75) exp_q.push_back(mk("bot_hit", ev(198, 302, 0, 0, 1, 0, 0)));
      drive(1, 0);
      if (k >= 74) begin
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e.v) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
    end
  endtask

  // Ball now climbs; left-wall bounce at tick 175, top miss at tick 223, then hold.
  task automatic test_left_wall_top_miss;
    paddleTopX = 9'd0;
    for (int k = 76; k <= 223; k++) begin
      if (k == 174) exp_q.push_back(mk("lwall_tick174", ev(0, 104, 0, 0, 1, 0, 0)));
      if (k == 175) exp_q.push_back(mk("lwall_tick175", ev(2, 102, 1, 0, 1, 0, 0)));
      if (k == 222) exp_q.push_back(mk("top_tick222", ev(96, 8, 1, 0, 1, 0, 0)));
      if (k == 223) exp_q.push_back(mk("top_miss", ev(98, 8, 1, 0, 0, 0, 1)));
      drive(1, 0);
      if (k == 174 || k == 175 || k == 222 || k == 223) begin
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e.v) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
    end
    for (int h = 1; h <= 60; h++) begin
      if (h == 1)  exp_q.push_back(mk("top_hold1", ev(98, 8, 1, 0, 0, 0, 0)));
      if (h == 59) exp_q.push_back(mk("top_hold59", ev(98, 8, 1, 0, 0, 0, 0)));
      if (h == 60) exp_q.push_back(mk("top_recentre", ev(116, 156, 1, 0, 0, 0, 0)));
      drive(1, 0);
      if (h == 1 || h == 59 || h == 60) begin
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e.v) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
    end
  endtask

  task automatic test_bottom_miss;
    reset = 1'b1;
    drive(0, 0);
    reset = 1'b0;
    paddleBotX = 9'd0;
    drive(0, 1);
    for (int k = 1; k <= 75; k++) begin
      if (k == 75) exp_q.push_back(mk("bot_miss", ev(198, 304, 0, 1, 0, 1, 0)));
      drive(1, 0);
      if (k == 75) begin
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e.v) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
    end
    exp_q.push_back(mk("pulse_one_clock_serve_ignored", ev(198, 304, 0, 1, 0, 0, 0)));
    drive(0, 1);
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    end
    for (int h = 1; h <= 60; h++) begin
      if (h == 59) exp_q.push_back(mk("bot_hold59", ev(198, 304, 0, 1, 0, 0, 0)));
      if (h == 60) exp_q.push_back(mk("bot_recentre", ev(116, 156, 1, 1, 0, 0, 0)));
      drive(1, 1);
      if (h >= 59) begin
        e = exp_q.pop_front();
        n_vec++;
        if (obs !== e.v) begin
          n_bad++;
          $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
        end
      end
    end
    exp_q.push_back(mk("idle_after_hold", ev(116, 156, 1, 1, 0, 0, 0)));
    exp_q.push_back(mk("reserve", ev(116, 156, 1, 1, 1, 0, 0)));
    drive(1, 0);
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    end
    drive(0, 1);
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    end
  endtask

  // Ball is in MOVE from the previous test; reset it mid-flight, then mid-hold.
  task automatic test_reset_mid;
    for (int k = 1; k <= 10; k++) drive(1, 0);
    exp_q.push_back(mk("reset_mid_move", ev(116, 156, 1, 1, 0, 0, 0)));
    reset = 1'b1;
    drive(1, 1);
    reset = 1'b0;
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    end
    paddleBotX = 9'd0;
    drive(0, 1);
    for (int k = 1; k <= 78; k++) drive(1, 0);
    exp_q.push_back(mk("reset_mid_scored", ev(116, 156, 1, 1, 0, 0, 0)));
    exp_q.push_back(mk("idle_after_reset", ev(116, 156, 1, 1, 0, 0, 0)));
    reset = 1'b1;
    drive(1, 0);
    reset = 1'b0;
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    end
    drive(1, 0);
    e = exp_q.pop_front();
    n_vec++;
    if (obs !== e.v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", e.name, obs, e.v);
    end
  endtask

  initial begin
    test_reset();
    test_serve_motion();
    test_right_wall();
    test_bottom_hit();
    test_left_wall_top_miss();
    test_bottom_miss();
    test_reset_mid();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no completion expected completion within 1 ms");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/ball_physics.md
# ball_physics

Frame-rate ball motion engine for the ping-pong game. It consumes the single-cycle frame tick from the refresh-rate generator (50 MHz domain). On each tick it advances the ball, reflects it off the side walls and both paddles, and detects misses. It also runs the serve / point / hold sequence. Its outputs feed the LT24 renderer and the score keeper.

## Interface
Parameters:
- SCREEN_W, 240, playfield width in pixels (x axis)
- SCREEN_H, 320, playfield height in pixels (y axis)
- BALL_SIZE, 8, ball edge length in pixels
- PADDLE_W, 48, paddle width in pixels
- PADDLE_H, 8, paddle thickness; top paddle occupies y 0..PADDLE_H-1, bottom paddle occupies SCREEN_H-PADDLE_H..SCREEN_H-1
- SPEED, 2, pixels moved per axis per tick (1..7)
- HOLD_FRAMES, 60, ticks the ball stays frozen after a point

Ports:
- clock  in  1  50 MHz system clock; one clock domain
- reset  in  1  synchronous, active-high; overrides all other inputs
- refreshRate  in  1  one-cycle frame tick from the refresh-rate generator
- serve  in  1  level or pulse requesting a serve; sampled only in IDLE
- paddleTopX  in  9  left x of top paddle
- paddleBotX  in  9  left x of bottom paddle
- ballX  out  9  left x of ball
- ballY  out  9  top y of ball
- dirX  out  1  1 = moving right
- dirY  out  1  1 = moving down
- active  out  1  high in MOVE
- pointTop  out  1  one-cycle pulse: top player scored (bottom missed)
- pointBot  out  1  one-cycle pulse: bottom player scored (top missed)

## Operation
- Centre position: CX = SCREEN_W/2 - BALL_SIZE/2 = 116; CY = SCREEN_H/2 - BALL_SIZE/2 = 156.
- Movement limits:
  - XMAX = SCREEN_W - BALL_SIZE = 232.
  - YMIN = PADDLE_H = 8.
  - YMAX = SCREEN_H - PADDLE_H - BALL_SIZE = 304.
- Reset values: state=IDLE, ballX=116, ballY=156, dirX=1, dirY=1, active=0, pointTop=0, pointBot=0, hold counter=0.
- States:
  - IDLE: ball held at centre. refreshRate is ignored. serve=1 → MOVE.
  - MOVE: on each tick, compute nx = ballX ± SPEED and ny = ballY ± SPEED in signed 11-bit arithmetic. The X and Y axes are handled independently within the same tick.
    - X: if nx<0, set ballX=-nx and dirX=1. If nx>XMAX, set ballX=2*XMAX-nx and dirX=0. Otherwise ballX=nx.
    - Y, moving up: if ny<YMIN, test overlap against the top paddle using the new ballX.
    - Y, moving down: if ny>YMAX, test overlap against the bottom paddle using the new ballX.
    - Overlap condition: ballX_new+BALL_SIZE > padX AND ballX_new < padX+PADDLE_W.
    - Hit, top: ballY=2*YMIN-ny, dirY=1. Hit, bottom: ballY=2*YMAX-ny, dirY=0.
    - Miss: ballY is clamped to the limit (YMIN or YMAX). Pulse pointBot (top miss) or pointTop (bottom miss). Go to SCORED and clear the hold counter.
  - SCORED: ball frozen. Each tick increments the hold counter. On the tick that brings the count to HOLD_FRAMES, go to IDLE, recentre the ball, set dirX=1, and set dirY toward the player who conceded (dirY=0 if top missed, 1 if bottom missed).
- serve is ignored outside IDLE.
- Reset asserted mid-MOVE or mid-SCORED returns to the reset values on the next edge; no point pulse is emitted.

## Timing
- All outputs are registered. A tick on edge N produces new values visible after edge N.
- IDLE with serve=1 at edge N: state=MOVE and active=1 after edge N. No motion occurs on that edge, even if refreshRate=1 on the same cycle.
- The first motion happens on the first tick strictly after entering MOVE.
- pointTop and pointBot go high for exactly one clock, on the edge that enters SCORED.
- The SCORED→IDLE transition and recentring take effect on the HOLD_FRAMES-th tick edge.
- Latency from tick to position update: 1 clock. No pipeline stall; the next tick is never closer than one cycle.

## Structure
- Shared package pong_pkg holds:
  - the state encoding (IDLE=2'd0, MOVE=2'd1, SCORED=2'd2)
  - the screen, ball and paddle dimension constants, used also by the renderer and paddle controller
- One sub-module, ball_axis: a combinational per-axis step/reflect. Inputs are pos, dir, speed, lo, hi. Outputs are the new pos, the new dir, and an out-of-range flag. It is instantiated once for X and once for Y; ball_physics owns the paddle test and the FSM.

## Test plan
- Reset, then 5 ticks with no serve → ballX=116, ballY=156, active=0, no point pulses.
- serve=1 and refreshRate=1 in the same cycle, then 10 ticks → ballX=136, ballY=176; the serve-cycle tick caused no motion.
- Right-wall reflection: after a serve, tick 58 → ballX=232; tick 59 → ballX=230, dirX=0.
- Bottom paddle hit with paddleBotX=180: tick 75 → ballX=198, ballY=302, dirY=0, no point pulse.
- Bottom miss with paddleBotX=0: tick 75 → ballY=304, pointTop high for exactly 1 clock, active=0.
  - 59 further ticks → ball still frozen.
  - 60th tick → IDLE, ball at (116,156), dirY=1.
- Reset asserted mid-MOVE, and serve asserted during SCORED → outputs return to reset values; the serve during SCORED is ignored.
